// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Fetch-stage bundle covering the instruction-memory side and the
//            IF/ID side of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic [31:0] pc;
    logic [31:0] instr_code;
    logic        stall;
    logic        jump_taken;
    logic [25:0] jump_index;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_count,
        input  instr_code, stall, jump_taken, jump_index, branch_taken, branch_offset
    );

    modport slave (
        input  pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_count,
        output instr_code, stall, jump_taken, jump_index, branch_taken, branch_offset
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with IF/ID register, redirect, stall,
//            out-of-range halt and saturating fetch counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 40
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fetch_stage_if.master   fif
);

    localparam logic [31:0] c_last_addr = 32'(MEM_BYTES - 4);

    localparam logic [1:0] c_boot = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_halt = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_pc_plus4_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;

    logic        w_redirect;
    logic        w_fault;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    assign w_redirect      = fif.jump_taken | fif.branch_taken;
    assign w_fault         = !fif.stall && (r_pc > c_last_addr);
    assign w_jump_target   = {r_pc_plus4[31:28], fif.jump_index, 2'b00};
    assign w_branch_target = r_pc_plus4 + {{14{fif.branch_offset[15]}}, fif.branch_offset, 2'b00};

    // State and pipeline registers; active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_boot;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
            r_count    <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus4 <= w_pc_plus4_nxt;
            r_valid    <= w_valid_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_boot:  w_state_nxt = c_run;
            c_run:   if (!w_redirect && w_fault) w_state_nxt = c_halt;
            c_halt:  w_state_nxt = c_halt;
            default: w_state_nxt = c_boot;
        endcase
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_plus4_nxt = r_pc_plus4;
        w_valid_nxt    = r_valid;
        w_count_nxt    = r_count;
        case (r_state)
            c_run: begin
                if (w_redirect) begin
                    w_pc_nxt    = fif.jump_taken ? w_jump_target : w_branch_target;
                    w_instr_nxt = 32'd0;
                    w_valid_nxt = 1'b0;
                end else if (w_fault) begin
                    w_instr_nxt = 32'd0;
                    w_valid_nxt = 1'b0;
                end else if (!fif.stall) begin
                    w_instr_nxt    = fif.instr_code;
                    w_pc_plus4_nxt = r_pc + 32'd4;
                    w_pc_nxt       = r_pc + 32'd4;
                    w_valid_nxt    = 1'b1;
                    w_count_nxt    = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                end
            end
            default: w_valid_nxt = 1'b0;
        endcase
    end

    assign fif.pc             = r_pc;
    assign fif.if_id_instr    = r_instr;
    assign fif.if_id_pc_plus4 = r_pc_plus4;
    assign fif.if_id_valid    = r_valid;
    assign fif.halted         = (r_state == c_halt);
    assign fif.fetch_count    = r_count;

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
- Owns the PC and drives it to the memory's PC input.
- Captures the returned 32-bit instruction word into an IF/ID pipeline register for the decode stage.
- Handles stall, jump/branch redirect from decode, out-of-range fetch detection, and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 40, instruction memory size in bytes; the last legal fetch address is MEM_BYTES-4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- pc  output  32  current fetch address, to instruction memory
- instr_code  input  32  instruction word returned for pc (combinational memory read)
- stall  input  1  hold PC and IF/ID contents
- jump_taken  input  1  J-type redirect from decode
- jump_index  input  26  J-type target field
- branch_taken  input  1  branch redirect from decode
- branch_offset  input  16  signed word offset
- if_id_instr  output  32  captured instruction word
- if_id_pc_plus4  output  32  address of captured instruction + 4
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped on range fault
- fetch_count  output  16  instructions captured since reset

Behaviour:
- Reset is sampled at posedge; reset==0 has priority over all other inputs. On reset:
  - pc=RESET_PC
  - if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0
  - halted=0, fetch_count=0
  - state=BOOT
- Reset asserted mid-operation (any state, including HALT) discards any in-flight capture and redirect.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, giving memory contents time to settle.
  - No capture; pc unchanged; if_id_valid=0.
  - Transitions to RUN.
- RUN, priority per posedge: redirect > range fault > stall > sequential.
- Redirect (jump_taken or branch_taken):
  - Jump wins if both are asserted.
  - Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - Branch target = if_id_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}, mod 2^32.
  - pc<=target; if_id_instr<=0 (NOP bubble); if_id_valid<=0; fetch_count unchanged.
  - Redirect overrides stall.
  - The target is not range-checked at redirect time; the check happens on the next fetch.
- Range fault:
  - Condition: no redirect, stall==0, and pc > MEM_BYTES-4 (unsigned).
  - state<=HALT, halted<=1, if_id_valid<=0, if_id_instr<=0; pc holds.
- Stall (no redirect): pc, if_id_*, and fetch_count all hold.
  - A stall with pc out of range does not fault until the stall drops.
- Sequential fetch:
  - if_id_instr<=instr_code, if_id_pc_plus4<=pc+4, if_id_valid<=1, pc<=pc+4.
  - fetch_count increments and saturates at 16'hFFFF.
- HALT:
  - All inputs except reset are ignored.
  - pc, if_id_instr, if_id_pc_plus4, and fetch_count hold; if_id_valid=0; halted=1.
  - Exit is by reset only.
- Latency: an instruction presented at pc in cycle N appears on if_id_* after posedge N+1.
- One redirect costs exactly one bubble.
- pc is always word-aligned; PC arithmetic wraps mod 2^32.

Test Plan:
- Reset low 2 cycles, then high; memory holds 8C010000 at 0 and 8C020001 at 4 → BOOT cycle with if_id_valid=0. Next posedge: if_id_instr=8C010000, if_id_pc_plus4=4, pc=4, fetch_count=1. Following posedge: if_id_instr=8C020001, pc=8.
- Jump: with if_id_pc_plus4=20, assert jump_taken with jump_index=26'd6 → pc=24, if_id_valid=0, if_id_instr=0. Next posedge captures the word at 24 with if_id_pc_plus4=28.
- Branch and range fault:
  - With if_id_pc_plus4=28, assert branch_taken with offset=16'h0003 → pc=40. Next posedge: halted=1, if_id_valid=0, pc stays 40.
  - Subsequent stall/jump pulses have no effect until reset.
  - Negative offset 16'hFFFE with if_id_pc_plus4=12 → pc=4.
- Stall and priority:
  - stall held 3 cycles at pc=8 → pc, if_id_*, and fetch_count frozen. On release, sequential fetch resumes at 8.
  - stall and jump_taken asserted together → redirect taken.
  - jump_taken and branch_taken asserted together → jump target used.
- Reset mid-run: reset low at pc=16 with if_id_valid=1 → next posedge pc=0, if_id_valid=0, fetch_count=0, state BOOT. A reset from HALT clears halted.
- Saturation: force 65537 sequential fetches using a large MEM_BYTES → fetch_count stays at 16'hFFFF.
